// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus interconnect.
// The optional error capture logic is enabled by defining DBUS_ERR_CAPTURE_EN.
package dbus_pkg;

  localparam int          SLAVEADDR_WIDTH   = 24;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    CAPT = 1'b1
  } err_state_e;

  // Upper `width` address bits, right-aligned so they compare directly against a slave base
  function automatic logic [31:0] base_of(input logic [31:0] addr, input int width);
    return addr >> (32 - width);
  endfunction

endpackage

// File: rtl/dbus_decoder.sv
// Fixed-priority address decoder: the lowest-indexed matching slave wins,
// so at most one bit of hit_o is set.
module dbus_decoder
  import dbus_pkg::*;
#(
  parameter int                                    NUM_SLAVES     = 4,
  parameter int                                    BASEADDR_WIDTH = 8,
  parameter logic [NUM_SLAVES*BASEADDR_WIDTH-1:0] SLAVE_BASE     = {8'h03, 8'h02, 8'h01, 8'h00}
) (
  input  logic [31:0]           addr_i,
  output logic [NUM_SLAVES-1:0] hit_o
);

  logic found;

  always_comb begin
    hit_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found &&
          base_of(addr_i, BASEADDR_WIDTH) ==
          32'(SLAVE_BASE[i*BASEADDR_WIDTH +: BASEADDR_WIDTH])) begin
        hit_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbus_interconnect.sv
// Core data port to NUM_SLAVES peripherals: decode, registered read mux and
// first-unmapped-access capture (present only when DBUS_ERR_CAPTURE_EN is defined).
module dbus_interconnect
  import dbus_pkg::*;
#(
  parameter int                                    NUM_SLAVES     = 4,
  parameter int                                    BASEADDR_WIDTH = 8,
  parameter logic [NUM_SLAVES*BASEADDR_WIDTH-1:0] SLAVE_BASE     = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter logic [31:0]                           ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dmem_rd,
  input  logic [31:0]                dmem_raddr,
  output logic [31:0]                dmem_rdata,
  input  logic                       dmem_wr,
  input  logic [31:0]                dmem_waddr,
  input  logic [31:0]                dmem_wdata,
  input  logic [3:0]                 dmem_wstrb,
  output logic [NUM_SLAVES-1:0]      slv_rd,
  output logic [SLAVEADDR_WIDTH-1:0] slv_raddr,
  input  logic [NUM_SLAVES*32-1:0]   slv_rdata,
  output logic [NUM_SLAVES-1:0]      slv_wr,
  output logic [SLAVEADDR_WIDTH-1:0] slv_waddr,
  output logic [31:0]                slv_wdata,
  output logic [3:0]                 slv_wstrb,
  input  logic                       err_clr,
  output logic                       err_valid,
  output logic [31:0]                err_addr,
  output logic                       err_is_wr,
  output logic [7:0]                 err_count
);

  logic [NUM_SLAVES-1:0] hit_r, hit_w;
  logic [NUM_SLAVES-1:0] rsel_q;
  logic                  unm_r, unm_w;

  dbus_decoder #(
    .NUM_SLAVES(NUM_SLAVES), .BASEADDR_WIDTH(BASEADDR_WIDTH), .SLAVE_BASE(SLAVE_BASE)
  ) u_dec_rd (
    .addr_i(dmem_raddr),
    .hit_o (hit_r)
  );

  dbus_decoder #(
    .NUM_SLAVES(NUM_SLAVES), .BASEADDR_WIDTH(BASEADDR_WIDTH), .SLAVE_BASE(SLAVE_BASE)
  ) u_dec_wr (
    .addr_i(dmem_waddr),
    .hit_o (hit_w)
  );

  assign slv_rd    = hit_r & {NUM_SLAVES{dmem_rd}};
  assign slv_wr    = hit_w & {NUM_SLAVES{dmem_wr}};
  assign slv_raddr = dmem_raddr[SLAVEADDR_WIDTH-1:0];
  assign slv_waddr = dmem_waddr[SLAVEADDR_WIDTH-1:0];
  assign slv_wdata = dmem_wdata;
  assign slv_wstrb = dmem_wstrb;
  assign unm_r     = dmem_rd & ~|hit_r;
  assign unm_w     = dmem_wr & ~|hit_w;

  // Slaves answer one cycle after the strobe, so the select is registered to line up
  always_ff @(posedge clk) begin
    if (rst) rsel_q <= '0;
    else     rsel_q <= slv_rd;
  end

`ifdef DBUS_ERR_CAPTURE_EN
  logic       rerr_q;
  err_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        iswr_q, iswr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      rerr_q  <= 1'b0;
      state_q <= IDLE;
      addr_q  <= '0;
      iswr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rerr_q  <= unm_r;
      state_q <= state_d;
      addr_q  <= addr_d;
      iswr_q  <= iswr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear is applied first so a coincident unmapped access is captured afresh
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iswr_d  = iswr_q;
    cnt_d   = cnt_q;
    if (err_clr) begin
      state_d = IDLE;
      addr_d  = '0;
      iswr_d  = 1'b0;
      cnt_d   = '0;
    end
    cnt_sum = {1'b0, cnt_d} + {8'd0, unm_r} + {8'd0, unm_w};
    if (unm_r || unm_w) begin
      cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      if (state_d == IDLE) begin
        state_d = CAPT;
        addr_d  = unm_w ? dmem_waddr : dmem_raddr;
        iswr_d  = unm_w;
      end
    end
  end

  always_comb begin
    err_valid = (state_q == CAPT);
    err_addr  = addr_q;
    err_is_wr = iswr_q;
    err_count = cnt_q;
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr ^ unm_r ^ unm_w;
  assign err_valid      = 1'b0;
  assign err_addr       = '0;
  assign err_is_wr      = 1'b0;
  assign err_count      = '0;
`endif

  always_comb begin
    dmem_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (rsel_q[i]) dmem_rdata = slv_rdata[i*32 +: 32];
    end
`ifdef DBUS_ERR_CAPTURE_EN
    if (rsel_q == '0 && rerr_q) dmem_rdata = ERR_RDATA;
`endif
  end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed self-checking bench for dbus_interconnect; error-capture expectations
// follow whether DBUS_ERR_CAPTURE_EN is defined for the build.
module tb_dbus_interconnect;

`ifdef DBUS_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam logic [31:0] D0 = 32'h0000_AAAA;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h1234_5678;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] EXP_ERR = CAP ? 32'hDEAD_BEEF : 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmemRd, dmemWr, errClr;
  logic [31:0] dmemRaddr, dmemWaddr, dmemWdata;
  logic [3:0]  dmemWstrb;
  logic [127:0] slvRdata;
  logic [31:0] dmemRdata, ovlRdata;
  logic [3:0]  slvRd, slvWr, ovlRd, ovlWr;
  logic [23:0] slvRaddr, slvWaddr, ovlRaddr, ovlWaddr;
  logic [31:0] slvWdata, ovlWdata;
  logic [3:0]  slvWstrb, ovlWstrb;
  logic        errValid, errIsWr, ovlErrValid, ovlErrIsWr;
  logic [31:0] errAddr, ovlErrAddr;
  logic [7:0]  errCount, ovlErrCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign slvRdata = {D3, D2, D1, D0};

  dbus_interconnect dut (
    .clk(clk), .rst(rst),
    .dmem_rd(dmemRd), .dmem_raddr(dmemRaddr), .dmem_rdata(dmemRdata),
    .dmem_wr(dmemWr), .dmem_waddr(dmemWaddr), .dmem_wdata(dmemWdata), .dmem_wstrb(dmemWstrb),
    .slv_rd(slvRd), .slv_raddr(slvRaddr), .slv_rdata(slvRdata),
    .slv_wr(slvWr), .slv_waddr(slvWaddr), .slv_wdata(slvWdata), .slv_wstrb(slvWstrb),
    .err_clr(errClr), .err_valid(errValid), .err_addr(errAddr),
    .err_is_wr(errIsWr), .err_count(errCount)
  );

  dbus_interconnect #(.SLAVE_BASE({8'h01, 8'h01, 8'h02, 8'h00})) dutOvl (
    .clk(clk), .rst(rst),
    .dmem_rd(dmemRd), .dmem_raddr(dmemRaddr), .dmem_rdata(ovlRdata),
    .dmem_wr(dmemWr), .dmem_waddr(dmemWaddr), .dmem_wdata(dmemWdata), .dmem_wstrb(dmemWstrb),
    .slv_rd(ovlRd), .slv_raddr(ovlRaddr), .slv_rdata(slvRdata),
    .slv_wr(ovlWr), .slv_waddr(ovlWaddr), .slv_wdata(ovlWdata), .slv_wstrb(ovlWstrb),
    .err_clr(errClr), .err_valid(ovlErrValid), .err_addr(ovlErrAddr),
    .err_is_wr(ovlErrIsWr), .err_count(ovlErrCount)
  );

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives all core-side inputs at once; called just after a rising edge
  task automatic applyStimulus(input logic rd, input logic [31:0] raddr,
                               input logic wr, input logic [31:0] waddr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic clr);
    dmemRd    = rd;
    dmemRaddr = raddr;
    dmemWr    = wr;
    dmemWaddr = waddr;
    dmemWdata = wdata;
    dmemWstrb = wstrb;
    errClr    = clr;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // Unmapped-error outputs against hand-computed values (zero when capture is absent)
  task automatic checkErr(input string tag, input logic valid, input logic [31:0] addr,
                          input logic isWr, input logic [7:0] cnt);
    checkOutput({tag, "_valid"}, 32'(errValid), CAP ? 32'(valid) : 32'h0);
    checkOutput({tag, "_addr"},  errAddr,       CAP ? addr : 32'h0);
    checkOutput({tag, "_iswr"},  32'(errIsWr),  CAP ? 32'(isWr) : 32'h0);
    checkOutput({tag, "_count"}, 32'(errCount), CAP ? 32'(cnt) : 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) nextCycle();
    rst = 1'b0;
    checkOutput("rst_rdata", dmemRdata, 32'h0);
    checkErr("rst", 1'b0, 32'h0, 1'b0, 8'd0);

    // Mapped write to slave 1
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0100_0010, 32'hCAFE_F00D, 4'b0011, 1'b0);
    checkOutput("wr_strobe", 32'(slvWr), 32'h2);
    checkOutput("wr_addr", 32'(slvWaddr), 32'h10);
    checkOutput("wr_wstrb", 32'(slvWstrb), 32'h3);
    checkOutput("wr_wdata", slvWdata, 32'hCAFE_F00D);
    checkOutput("wr_no_rd", 32'(slvRd), 32'h0);
    nextCycle();
    idle();
    checkOutput("wr_strobe_gone", 32'(slvWr), 32'h0);

    // Mapped read of slave 2, data one cycle later
    applyStimulus(1'b1, 32'h0200_0004, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkOutput("rd_strobe", 32'(slvRd), 32'h4);
    checkOutput("rd_addr", 32'(slvRaddr), 32'h4);
    nextCycle();
    idle();
    checkOutput("rd_data", dmemRdata, D2);
    nextCycle();
    checkOutput("rd_data_idle", dmemRdata, 32'h0);

    // Back-to-back reads of slaves 0, 3, 1
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h0300_0000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkOutput("b2b_s0", dmemRdata, D0);
    nextCycle();
    applyStimulus(1'b1, 32'h0100_0000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkOutput("b2b_s3", dmemRdata, D3);
    nextCycle();
    idle();
    checkOutput("b2b_s1", dmemRdata, D1);

    // Simultaneous read of slave 1 and write of slave 3
    applyStimulus(1'b1, 32'h0100_0020, 1'b1, 32'h0300_0040, 32'h5, 4'hF, 1'b0);
    checkOutput("rw_rd", 32'(slvRd), 32'h2);
    checkOutput("rw_wr", 32'(slvWr), 32'h8);
    nextCycle();
    idle();
    checkOutput("rw_data", dmemRdata, D1);

    // Unmapped read, then unmapped write
    applyStimulus(1'b1, 32'h0700_0000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkOutput("unm_rd_strobe", 32'(slvRd), 32'h0);
    nextCycle();
    idle();
    checkOutput("unm_rd_data", dmemRdata, EXP_ERR);
    checkErr("unm_rd", 1'b1, 32'h0700_0000, 1'b0, 8'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0900_0000, 32'h1, 4'hF, 1'b0);
    checkOutput("unm_wr_strobe", 32'(slvWr), 32'h0);
    nextCycle();
    idle();
    checkOutput("unm_wr_rdata", dmemRdata, 32'h0);
    checkErr("unm_wr", 1'b1, 32'h0700_0000, 1'b0, 8'd2);

    // 300 more unmapped writes saturate the counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0900_0000 + 32'(i), 32'h0, 4'hF, 1'b0);
      nextCycle();
    end
    idle();
    checkErr("sat", 1'b1, 32'h0700_0000, 1'b0, 8'd255);

    // Clear together with an unmapped write captures the new write
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0A00_0000, 32'h0, 4'hF, 1'b1);
    nextCycle();
    idle();
    checkErr("clr_wr", 1'b1, 32'h0A00_0000, 1'b1, 8'd1);

    // Clear with unmapped read and write together: count 2, write address latched
    applyStimulus(1'b1, 32'h0B00_0000, 1'b1, 32'h0C00_0000, 32'h0, 4'hF, 1'b1);
    nextCycle();
    idle();
    checkErr("clr_rw", 1'b1, 32'h0C00_0000, 1'b1, 8'd2);

    // Plain clear returns to idle
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    nextCycle();
    idle();
    checkErr("clr", 1'b0, 32'h0, 1'b0, 8'd0);

    // Reset during an unmapped read discards both read data and the capture
    rst = 1'b1;
    applyStimulus(1'b1, 32'h0700_0000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    nextCycle();
    rst = 1'b0;
    idle();
    checkOutput("rst_mid_rdata", dmemRdata, 32'h0);
    checkErr("rst_mid", 1'b0, 32'h0, 1'b0, 8'd0);

    // Reset during a mapped read also returns zero
    rst = 1'b1;
    applyStimulus(1'b1, 32'h0200_0000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    nextCycle();
    rst = 1'b0;
    idle();
    checkOutput("rst_map_rdata", dmemRdata, 32'h0);

    // Overlapping bases: lowest index wins
    applyStimulus(1'b1, 32'h0100_0000, 1'b1, 32'h0200_0000, 32'h0, 4'hF, 1'b0);
    checkOutput("ovl_rd", 32'(ovlRd), 32'h4);
    checkOutput("ovl_wr", 32'(ovlWr), 32'h2);
    nextCycle();
    idle();
    checkOutput("ovl_data", ovlRdata, D2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_interconnect.md
# dbus_interconnect

Parametrised data-bus interconnect between the RISC-V core's data port and `NUM_SLAVES` memory-mapped peripherals. It replaces the per-slave read/write bus instances and the hand-written read-data mux with one block. It decodes the top address byte with fixed priority, registers the read-select for the slaves' one-cycle read latency, and returns a defined error word for unmapped reads. It also latches the first unmapped access for software diagnosis.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `BASEADDR_WIDTH`, 8: number of upper address bits compared against a slave base.
- `SLAVE_BASE`, {8'h03,8'h02,8'h01,8'h00}: packed `NUM_SLAVES*BASEADDR_WIDTH` bits; slice i is the base of slave i.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned for an unmapped read.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `dmem_rd` in 1: core read strobe.
- `dmem_raddr` in 32: core read address.
- `dmem_rdata` out 32: read data, valid one cycle after `dmem_rd`.
- `dmem_wr` in 1: core write strobe.
- `dmem_waddr` in 32: core write address.
- `dmem_wdata` in 32: core write data.
- `dmem_wstrb` in 4: core write byte enables.
- `slv_rd` out `NUM_SLAVES`: one-hot per-slave read strobe.
- `slv_raddr` out 24: `dmem_raddr[23:0]`, broadcast to all slaves.
- `slv_rdata` in `NUM_SLAVES*32`: slave read data; slice i belongs to slave i.
- `slv_wr` out `NUM_SLAVES`: one-hot per-slave write strobe.
- `slv_waddr` out 24: `dmem_waddr[23:0]`, broadcast.
- `slv_wdata` out 32: broadcast write data.
- `slv_wstrb` out 4: broadcast write byte enables.
- `err_clr` in 1: clears the error capture state.
- `err_valid` out 1: sticky flag; an unmapped access has occurred.
- `err_addr` out 32: address of the first unmapped access.
- `err_is_wr` out 1: the first unmapped access was a write.
- `err_count` out 8: number of unmapped accesses, saturating.

## Operation
- **Decode.** Slave i matches when `addr[31:32-BASEADDR_WIDTH] == SLAVE_BASE[i]`.
  - If bases overlap, the lowest index wins, so at most one strobe is active.
  - Each slave ignores the `slv_*addr` bits above its own address width.
- **Write path.** Purely combinational.
  - `slv_wr[i] = dmem_wr & hit_w[i]`.
  - Data and strobes are broadcast to all slaves.
  - An unmapped write asserts no `slv_wr`.
- **Read path.**
  - `slv_rd[i] = dmem_rd & hit_r[i]`, combinational.
  - Each cycle, the registers update as follows:
    - `rsel <= slv_rd` (one-hot or zero).
    - `rerr <= dmem_rd & ~|hit_r`.
  - `dmem_rdata` is selected from these registers:
    - `rsel` non-zero: `slv_rdata[rsel]`.
    - otherwise `rerr` set: `ERR_RDATA`.
    - otherwise: 0.
- **Error capture state machine:**
  - IDLE: on an unmapped `dmem_rd` or `dmem_wr`, go to CAPT.
    - Latch `err_addr`; `err_is_wr` = 1 for a write.
    - `err_count` increments.
  - CAPT: `err_addr` and `err_is_wr` hold.
    - Further unmapped accesses only increment `err_count`, saturating at 255.
    - `err_clr` returns the state to IDLE.
  - Read and write unmapped in the same cycle: `err_count` increments by 2 and the write address is latched.
  - `err_clr` coinciding with a new unmapped access: the clear takes effect and the new access is captured. The state becomes CAPT and `err_count` = 1 (or 2 if both a read and a write are unmapped).
- Reads and writes are independent and may target different slaves, or the same slave, in the same cycle.

## Timing
- `slv_rd`, `slv_wr`, addresses and write data: zero-cycle combinational.
- Read data: one cycle after `dmem_rd`. This matches the slaves' registered read.
- Back-to-back reads to different slaves: `rsel` follows every cycle with no bubble.
- Reset values: `rsel` = 0, `rerr` = 0, so `dmem_rdata` = 0.
  - `err_valid` = 0, `err_addr` = 0, `err_is_wr` = 0, `err_count` = 0.
- `rst` mid-read: the read data in the following cycle is 0, and any captured error is discarded.

## Configuration
- `DBUS_ERR_CAPTURE_EN` defined:
  - The error state machine and its registers are present.
  - Unmapped reads return `ERR_RDATA`.
- `DBUS_ERR_CAPTURE_EN` undefined:
  - `err_valid`, `err_addr`, `err_is_wr` and `err_count` are tied to 0.
  - `err_clr` is ignored.
  - `rerr` is removed, so unmapped reads return 0.
  - Decode and the data path are unchanged.

## Structure
- Package `dbus_pkg`:
  - `SLAVEADDR_WIDTH` = 24.
  - Default `ERR_RDATA`.
  - The error state enum (IDLE, CAPT).
  - Function `base_of(addr, width)`.
- Sub-module `dbus_decoder`: address to one-hot, fixed priority, purely combinational. It is instantiated twice, once for reads and once for writes.

## Test plan
- Write 32'h0100_0010, wstrb 4'b0011 -> `slv_wr` = 4'b0010 for that cycle only; `slv_waddr` = 24'h10; `slv_wstrb` = 4'b0011.
- Read 32'h0200_0004 while slave 2 drives 32'h1234_5678 -> `slv_rd` = 4'b0100; next cycle `dmem_rdata` = 32'h1234_5678.
- Back-to-back reads of slaves 0, 3, 1 -> `dmem_rdata` shows the data of slaves 0, 3, 1 on consecutive cycles with no bubble.
- Read 32'h0700_0000 -> no `slv_rd`; next cycle `dmem_rdata` = 32'hDEAD_BEEF; `err_valid` = 1, `err_addr` = 32'h0700_0000, `err_count` = 1. A following unmapped write at 32'h0900_0000 -> `err_addr` unchanged, `err_count` = 2.
- 300 unmapped accesses -> `err_count` = 255. `err_clr` in the same cycle as an unmapped write -> `err_count` = 1, `err_is_wr` = 1.
- Overlap: `SLAVE_BASE` = {8'h01,8'h01,8'h02,8'h00}, read 32'h0100_0000 -> only `slv_rd[2]` asserted. `rst` asserted during a read -> next cycle `dmem_rdata` = 0.
